// File: rtl/axi_lite_pkg.sv
// Shared types and helpers for the AXI4-Lite register slave.
// The SLVERR response is only generated when AXI_LITE_REG_SLV_ERR_EN is defined.
package axi_lite_pkg;

   localparam int AXI_DATA_W = 32;
   localparam int STRB_W     = AXI_DATA_W / 8;
   localparam int ADDR_LSB   = 2;

   typedef enum logic [1:0] {
      RESP_OKAY   = 2'b00,
      RESP_SLVERR = 2'b10
   } resp_e;

   // Replace only the byte lanes whose strobe bit is set.
   function automatic logic [AXI_DATA_W-1:0] strbMerge(
      input logic [AXI_DATA_W-1:0] oldWord,
      input logic [AXI_DATA_W-1:0] newWord,
      input logic [STRB_W-1:0]     strb
   );
      logic [AXI_DATA_W-1:0] merged;
      merged = oldWord;
      for (int i = 0; i < STRB_W; i++) begin
         if (strb[i]) merged[8*i +: 8] = newWord[8*i +: 8];
      end
      return merged;
   endfunction

endpackage

// File: rtl/axi_lite_wr_capture.sv
// Write-side capture for the AXI4-Lite register slave: independent one-deep AW and W
// holds, their ready signals, and the commit strobe that drains both together.
module axi_lite_wr_capture
   import axi_lite_pkg::*;
#(
   parameter int ADDR_W = 12
)(
   input  logic                  aclk,
   input  logic                  aresetn,
   input  logic [ADDR_W-1:0]     awaddr_i,
   input  logic                  awvalid_i,
   output logic                  awready_o,
   input  logic [AXI_DATA_W-1:0] wdata_i,
   input  logic [STRB_W-1:0]     wstrb_i,
   input  logic                  wvalid_i,
   output logic                  wready_o,
   input  logic                  bvalid_i,
   output logic                  commit_o,
   output logic [ADDR_W-1:0]     addr_o,
   output logic [AXI_DATA_W-1:0] data_o,
   output logic [STRB_W-1:0]     strb_o
);

   logic                  awHold_q, awHold_d;
   logic                  wHold_q, wHold_d;
   logic [ADDR_W-1:0]     addr_q, addr_d;
   logic [AXI_DATA_W-1:0] data_q, data_d;
   logic [STRB_W-1:0]     strb_q, strb_d;
   logic                  awFire, wFire;

   assign awready_o = aresetn & ~awHold_q;
   assign wready_o  = aresetn & ~wHold_q;
   assign awFire    = awvalid_i & awready_o;
   assign wFire     = wvalid_i & wready_o;
   // A commit must wait for the previous response to be taken.
   assign commit_o  = awHold_q & wHold_q & ~bvalid_i;
   assign addr_o    = addr_q;
   assign data_o    = data_q;
   assign strb_o    = strb_q;

   always_comb begin
      awHold_d = awHold_q;
      wHold_d  = wHold_q;
      addr_d   = addr_q;
      data_d   = data_q;
      strb_d   = strb_q;
      if (commit_o) begin
         awHold_d = 1'b0;
         wHold_d  = 1'b0;
      end
      if (awFire) begin
         awHold_d = 1'b1;
         addr_d   = awaddr_i;
      end
      if (wFire) begin
         wHold_d = 1'b1;
         data_d  = wdata_i;
         strb_d  = wstrb_i;
      end
   end

   always_ff @(posedge aclk) begin
      if (!aresetn) begin
         awHold_q <= 1'b0;
         wHold_q  <= 1'b0;
         addr_q   <= '0;
         data_q   <= '0;
         strb_q   <= '0;
      end else begin
         awHold_q <= awHold_d;
         wHold_q  <= wHold_d;
         addr_q   <= addr_d;
         data_q   <= data_d;
         strb_q   <= strb_d;
      end
   end

endmodule

// File: rtl/axi_lite_reg_slave.sv
// AXI4-Lite slave over a bank of 32-bit registers; register 0 is a read-only ID word.
// Define AXI_LITE_REG_SLV_ERR_EN to answer out-of-range accesses and ID writes with SLVERR.
module axi_lite_reg_slave
   import axi_lite_pkg::*;
#(
   parameter int          ADDR_W   = 12,
   parameter int          DATA_W   = 32,
   parameter int          NUM_REGS = 16,
   parameter logic [31:0] ID_VALUE = 32'hA11E_0001
)(
   input  logic                aclk,
   input  logic                aresetn,
   input  logic [ADDR_W-1:0]   s_axi_awaddr,
   input  logic                s_axi_awvalid,
   output logic                s_axi_awready,
   input  logic [DATA_W-1:0]   s_axi_wdata,
   input  logic [DATA_W/8-1:0] s_axi_wstrb,
   input  logic                s_axi_wvalid,
   output logic                s_axi_wready,
   output logic [1:0]          s_axi_bresp,
   output logic                s_axi_bvalid,
   input  logic                s_axi_bready,
   input  logic [ADDR_W-1:0]   s_axi_araddr,
   input  logic                s_axi_arvalid,
   output logic                s_axi_arready,
   output logic [DATA_W-1:0]   s_axi_rdata,
   output logic [1:0]          s_axi_rresp,
   output logic                s_axi_rvalid,
   input  logic                s_axi_rready
);

   localparam int IDXF_W = ADDR_W - ADDR_LSB;
   localparam int IDX_W  = (NUM_REGS > 1) ? $clog2(NUM_REGS) : 1;

   if (DATA_W != 32) begin : gDataWidthCheck
      $error("axi_lite_reg_slave: DATA_W must be 32");
   end
   if (NUM_REGS < 2 || NUM_REGS > (1 << IDXF_W)) begin : gNumRegsCheck
      $error("axi_lite_reg_slave: NUM_REGS out of range");
   end

   logic [DATA_W-1:0] regs_q [NUM_REGS];

   logic              commit;
   logic [ADDR_W-1:0] cmtAddr;
   logic [DATA_W-1:0] cmtData;
   logic [STRB_W-1:0] cmtStrb;

   logic [IDXF_W-1:0] wIdxFull, rIdxFull;
   logic [IDX_W-1:0]  wIdx, rIdx;
   logic              wInRange, rInRange, wIsId, rIsId, arFire;
   logic [DATA_W-1:0] rdWord;
   resp_e             wrResp, rdResp;
   logic              unusedAddrBits;

   logic              bvalid_q, bvalid_d, rvalid_q, rvalid_d;
   resp_e             bresp_q, bresp_d, rresp_q, rresp_d;
   logic [DATA_W-1:0] rdata_q, rdata_d;

   axi_lite_wr_capture #(.ADDR_W(ADDR_W)) uWrCapture (
      .aclk      (aclk),
      .aresetn   (aresetn),
      .awaddr_i  (s_axi_awaddr),
      .awvalid_i (s_axi_awvalid),
      .awready_o (s_axi_awready),
      .wdata_i   (s_axi_wdata),
      .wstrb_i   (s_axi_wstrb),
      .wvalid_i  (s_axi_wvalid),
      .wready_o  (s_axi_wready),
      .bvalid_i  (bvalid_q),
      .commit_o  (commit),
      .addr_o    (cmtAddr),
      .data_o    (cmtData),
      .strb_o    (cmtStrb)
   );

   assign wIdxFull       = cmtAddr[ADDR_W-1:ADDR_LSB];
   assign rIdxFull       = s_axi_araddr[ADDR_W-1:ADDR_LSB];
   assign wIdx           = wIdxFull[IDX_W-1:0];
   assign rIdx           = rIdxFull[IDX_W-1:0];
   assign wInRange       = 32'(wIdxFull) < NUM_REGS;
   assign rInRange       = 32'(rIdxFull) < NUM_REGS;
   assign wIsId          = (wIdxFull == '0);
   assign rIsId          = (rIdxFull == '0);
   assign unusedAddrBits = ^{cmtAddr[ADDR_LSB-1:0], s_axi_araddr[ADDR_LSB-1:0]};

   assign s_axi_arready = aresetn & ~rvalid_q;
   assign arFire        = s_axi_arvalid & s_axi_arready;
   assign rdWord        = !rInRange ? '0 : (rIsId ? ID_VALUE : regs_q[rIdx]);

`ifdef AXI_LITE_REG_SLV_ERR_EN
   assign wrResp = (!wInRange || wIsId) ? RESP_SLVERR : RESP_OKAY;
   assign rdResp = rInRange ? RESP_OKAY : RESP_SLVERR;
`else
   assign wrResp = RESP_OKAY;
   assign rdResp = RESP_OKAY;
`endif

   // Register 0 is never written; its storage slot simply stays at reset value.
   always_ff @(posedge aclk) begin
      if (!aresetn) begin
         for (int i = 0; i < NUM_REGS; i++) regs_q[i] <= '0;
      end else if (commit && wInRange && !wIsId) begin
         regs_q[wIdx] <= strbMerge(regs_q[wIdx], cmtData, cmtStrb);
      end
   end

   always_comb begin
      bvalid_d = bvalid_q;
      bresp_d  = bresp_q;
      rvalid_d = rvalid_q;
      rresp_d  = rresp_q;
      rdata_d  = rdata_q;
      if (bvalid_q && s_axi_bready) bvalid_d = 1'b0;
      if (commit) begin
         bvalid_d = 1'b1;
         bresp_d  = wrResp;
      end
      if (rvalid_q && s_axi_rready) rvalid_d = 1'b0;
      if (arFire) begin
         rvalid_d = 1'b1;
         rresp_d  = rdResp;
         rdata_d  = rdWord;
      end
   end

   always_ff @(posedge aclk) begin
      if (!aresetn) begin
         bvalid_q <= 1'b0;
         bresp_q  <= RESP_OKAY;
         rvalid_q <= 1'b0;
         rresp_q  <= RESP_OKAY;
         rdata_q  <= '0;
      end else begin
         bvalid_q <= bvalid_d;
         bresp_q  <= bresp_d;
         rvalid_q <= rvalid_d;
         rresp_q  <= rresp_d;
         rdata_q  <= rdata_d;
      end
   end

   assign s_axi_bvalid = bvalid_q;
   assign s_axi_bresp  = bresp_q;
   assign s_axi_rvalid = rvalid_q;
   assign s_axi_rresp  = rresp_q;
   assign s_axi_rdata  = rdata_q;

endmodule
